// File: rtl/jtag_tap_responder.sv
// -----------------------------------------------------------------------------
// jtag_tap_responder
// TAP-side JTAG responder used to exercise the board-level stimulus sequencer
// without the ASIC attached. It follows the IEEE 1149.1 TAP state machine,
// decodes a 4-bit IR, and drives tdo with IDCODE, debug response data or the
// bypass bit. Every shifted DR payload is captured and reported when the scan
// passes through Update-DR.
//
// Ports
//   jtag_clk_i   TCK, all sampling on the rising edge
//   rst_n        asynchronous active-low reset
//   trstn        asynchronous active-low TAP reset (same effect as rst_n)
//   tms, tdi     TAP inputs
//   resp_data_i  DR payload loaded at Capture-DR when IR == DBG_IR
//   tdo          registered test data out
//   tap_state    current TAP state (IEEE encoding)
//   ir_o         current instruction
//   dr_valid     one-cycle pulse after Update-DR
//   dr_data      captured tdi bits, bit 0 = first shifted bit
//   dr_len       captured bit count, saturates at DR_MAX
//   dr_ir        instruction active for the reported DR
//   dr_overflow  more than DR_MAX bits were shifted
// -----------------------------------------------------------------------------
module jtag_tap_responder #(
    parameter int                  IR_WIDTH  = 4,
    parameter int                  DR_MAX    = 64,
    parameter logic [31:0]         IDCODE    = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0] IDCODE_IR = 4'h2,
    parameter logic [IR_WIDTH-1:0] DBG_IR    = 4'h8,
    parameter logic [IR_WIDTH-1:0] BYPASS_IR = 4'hF
) (
    input  logic                jtag_clk_i,
    input  logic                rst_n,
    input  logic                trstn,
    input  logic                tms,
    input  logic                tdi,
    input  logic [DR_MAX-1:0]   resp_data_i,
    output logic                tdo,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] ir_o,
    output logic                dr_valid,
    output logic [DR_MAX-1:0]   dr_data,
    output logic [7:0]          dr_len,
    output logic [IR_WIDTH-1:0] dr_ir,
    output logic                dr_overflow
);

    localparam logic [3:0] ST_TLR   = 4'hF;
    localparam logic [3:0] ST_RTI   = 4'hC;
    localparam logic [3:0] ST_SELDR = 4'h7;
    localparam logic [3:0] ST_CAPDR = 4'h6;
    localparam logic [3:0] ST_SHDR  = 4'h2;
    localparam logic [3:0] ST_EX1DR = 4'h1;
    localparam logic [3:0] ST_PSDR  = 4'h3;
    localparam logic [3:0] ST_EX2DR = 4'h0;
    localparam logic [3:0] ST_UPDR  = 4'h5;
    localparam logic [3:0] ST_SELIR = 4'h4;
    localparam logic [3:0] ST_CAPIR = 4'hE;
    localparam logic [3:0] ST_SHIR  = 4'hA;
    localparam logic [3:0] ST_EX1IR = 4'h9;
    localparam logic [3:0] ST_PSIR  = 4'hB;
    localparam logic [3:0] ST_EX2IR = 4'h8;
    localparam logic [3:0] ST_UPIR  = 4'hD;

    localparam logic [7:0]        DR_MAX_C   = 8'(DR_MAX);
    localparam logic [DR_MAX-1:0] IDCODE_EXT = {{(DR_MAX-32){1'b0}}, IDCODE};

    // Either reset input clears the whole responder.
    logic arst_n_s;
    assign arst_n_s = rst_n & trstn;

    logic [3:0]          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
    logic [DR_MAX-1:0]   dr_shift_q, dr_shift_d;
    logic                bypass_q, bypass_d;
    logic [DR_MAX-1:0]   cap_buf_q, cap_buf_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                tdo_q, tdo_d;
    logic                dr_valid_q, dr_valid_d;
    logic [DR_MAX-1:0]   dr_data_q, dr_data_d;
    logic [7:0]          dr_len_q, dr_len_d;
    logic [IR_WIDTH-1:0] dr_ir_q, dr_ir_d;
    logic                dr_ovf_q, dr_ovf_d;
    logic                sel_idcode_s, sel_dbg_s, sel_bypass_s;

    // Undefined opcodes fall through to the bypass path.
    assign sel_idcode_s = (ir_q == IDCODE_IR);
    assign sel_dbg_s    = (ir_q == DBG_IR);
    assign sel_bypass_s = (ir_q == BYPASS_IR) || !(sel_idcode_s || sel_dbg_s);

    // TAP controller next-state on tms.
    always_comb begin
        state_d = ST_TLR;
        case (state_q)
            ST_TLR:   state_d = tms ? ST_TLR   : ST_RTI;
            ST_RTI:   state_d = tms ? ST_SELDR : ST_RTI;
            ST_SELDR: state_d = tms ? ST_SELIR : ST_CAPDR;
            ST_CAPDR: state_d = tms ? ST_EX1DR : ST_SHDR;
            ST_SHDR:  state_d = tms ? ST_EX1DR : ST_SHDR;
            ST_EX1DR: state_d = tms ? ST_UPDR  : ST_PSDR;
            ST_PSDR:  state_d = tms ? ST_EX2DR : ST_PSDR;
            ST_EX2DR: state_d = tms ? ST_UPDR  : ST_SHDR;
            ST_UPDR:  state_d = tms ? ST_SELDR : ST_RTI;
            ST_SELIR: state_d = tms ? ST_TLR   : ST_CAPIR;
            ST_CAPIR: state_d = tms ? ST_EX1IR : ST_SHIR;
            ST_SHIR:  state_d = tms ? ST_EX1IR : ST_SHIR;
            ST_EX1IR: state_d = tms ? ST_UPIR  : ST_PSIR;
            ST_PSIR:  state_d = tms ? ST_EX2IR : ST_PSIR;
            ST_EX2IR: state_d = tms ? ST_UPIR  : ST_SHIR;
            ST_UPIR:  state_d = tms ? ST_SELDR : ST_RTI;
            default:  state_d = ST_TLR;
        endcase
    end

    // Per-state datapath actions, keyed on the state held before the edge.
    always_comb begin
        ir_d       = ir_q;
        ir_shift_d = ir_shift_q;
        dr_shift_d = dr_shift_q;
        bypass_d   = bypass_q;
        cap_buf_d  = cap_buf_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        tdo_d      = 1'b0;
        dr_valid_d = 1'b0;
        dr_data_d  = dr_data_q;
        dr_len_d   = dr_len_q;
        dr_ir_d    = dr_ir_q;
        dr_ovf_d   = dr_ovf_q;
        case (state_q)
            ST_TLR: begin
                ir_d = IDCODE_IR;
            end
            ST_CAPIR: begin
                ir_shift_d = {{(IR_WIDTH-2){1'b0}}, 2'b01};
            end
            ST_SHIR: begin
                tdo_d      = ir_shift_q[0];
                ir_shift_d = {tdi, ir_shift_q[IR_WIDTH-1:1]};
            end
            ST_UPIR: begin
                ir_d = ir_shift_q;
            end
            ST_CAPDR: begin
                if (sel_idcode_s) begin
                    dr_shift_d = IDCODE_EXT;
                end else if (sel_dbg_s) begin
                    dr_shift_d = resp_data_i;
                end else begin
                    dr_shift_d = '0;
                end
                bypass_d  = 1'b0;
                cap_buf_d = '0;
                cnt_d     = 8'd0;
                ovf_d     = 1'b0;
            end
            ST_SHDR: begin
                if (sel_bypass_s) begin
                    tdo_d    = bypass_q;
                    bypass_d = tdi;
                end else begin
                    tdo_d      = dr_shift_q[0];
                    dr_shift_d = {1'b0, dr_shift_q[DR_MAX-1:1]};
                end
                // Buffer is cleared at capture, so OR-ing in the new bit is safe.
                if (cnt_q < DR_MAX_C) begin
                    cap_buf_d = cap_buf_q | ({{(DR_MAX-1){1'b0}}, tdi} << cnt_q);
                    cnt_d     = cnt_q + 8'd1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            ST_UPDR: begin
                dr_data_d  = cap_buf_q;
                dr_len_d   = cnt_q;
                dr_ir_d    = ir_q;
                dr_ovf_d   = ovf_q;
                dr_valid_d = 1'b1;
            end
            default: begin
                tdo_d      = 1'b0;
                dr_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers, cleared by either asynchronous reset.
    always_ff @(posedge jtag_clk_i or negedge arst_n_s) begin
        if (!arst_n_s) begin
            state_q    <= ST_TLR;
            ir_q       <= IDCODE_IR;
            ir_shift_q <= '0;
            dr_shift_q <= '0;
            bypass_q   <= 1'b0;
            cap_buf_q  <= '0;
            cnt_q      <= 8'd0;
            ovf_q      <= 1'b0;
            tdo_q      <= 1'b0;
            dr_valid_q <= 1'b0;
            dr_data_q  <= '0;
            dr_len_q   <= 8'd0;
            dr_ir_q    <= '0;
            dr_ovf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_shift_q <= ir_shift_d;
            dr_shift_q <= dr_shift_d;
            bypass_q   <= bypass_d;
            cap_buf_q  <= cap_buf_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            tdo_q      <= tdo_d;
            dr_valid_q <= dr_valid_d;
            dr_data_q  <= dr_data_d;
            dr_len_q   <= dr_len_d;
            dr_ir_q    <= dr_ir_d;
            dr_ovf_q   <= dr_ovf_d;
        end
    end

    assign tdo         = tdo_q;
    assign tap_state   = state_q;
    assign ir_o        = ir_q;
    assign dr_valid    = dr_valid_q;
    assign dr_data     = dr_data_q;
    assign dr_len      = dr_len_q;
    assign dr_ir       = dr_ir_q;
    assign dr_overflow = dr_ovf_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
module tb_jtag_tap_responder;

    logic        jtag_clk_i = 1'b0;
    logic        rst_n, trstn, tms, tdi;
    logic [63:0] resp_data_i;
    logic        tdo, dr_valid, dr_overflow;
    logic [3:0]  tap_state, ir_o, dr_ir;
    logic [63:0] dr_data;
    logic [7:0]  dr_len;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: TAP transition table plus the current instruction.
    logic [3:0] nxt0 [0:15];
    logic [3:0] nxt1 [0:15];
    logic [3:0] m_state;
    logic [3:0] m_ir;

    always #5 jtag_clk_i = ~jtag_clk_i;

    jtag_tap_responder dut (
        .jtag_clk_i  (jtag_clk_i),
        .rst_n       (rst_n),
        .trstn       (trstn),
        .tms         (tms),
        .tdi         (tdi),
        .resp_data_i (resp_data_i),
        .tdo         (tdo),
        .tap_state   (tap_state),
        .ir_o        (ir_o),
        .dr_valid    (dr_valid),
        .dr_data     (dr_data),
        .dr_len      (dr_len),
        .dr_ir       (dr_ir),
        .dr_overflow (dr_overflow)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One TCK: drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic tms_v, input logic tdi_v);
        @(negedge jtag_clk_i);
        tms = tms_v;
        tdi = tdi_v;
        @(posedge jtag_clk_i);
        #1;
        m_state = tms_v ? nxt1[m_state] : nxt0[m_state];
        chk("tap_state", 64'(tap_state), 64'(m_state));
    endtask

    // From Run-Test/Idle: load a new instruction and return to Run-Test/Idle.
    task automatic shift_ir(input logic [3:0] val);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(i == 3, val[i]);
            // Capture pattern 0001 comes out LSB first.
            chk("ir_tdo", 64'(tdo), (i == 0) ? 64'd1 : 64'd0);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        m_ir = val;
        chk("ir_o", 64'(ir_o), 64'(m_ir));
    endtask

    // From Run-Test/Idle: one DR scan of n bits, optional pause after bit pause_at.
    task automatic shift_dr(input int n, input logic [127:0] bits,
                            input logic [63:0] rdata, input int pause_at);
        logic [63:0] src;
        logic [63:0] exp_data;
        logic        byp;
        logic        exp_bit;
        int          kept;
        resp_data_i = rdata;
        byp = !(m_ir == 4'h2 || m_ir == 4'h8);
        src = (m_ir == 4'h2) ? 64'h0000_0000_1000_0001 : rdata;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        if (n == 0) begin
            step(1'b1, 1'b0);
        end else begin
            step(1'b0, 1'b0);
            // Capture is done; later changes must not matter.
            resp_data_i = {$urandom(), $urandom()};
            for (int i = 0; i < n; i++) begin
                step((i == n - 1) || (i == pause_at), bits[i]);
                if (byp) begin
                    if (i == 0) exp_bit = 1'b0;
                    else        exp_bit = bits[i-1];
                end else begin
                    exp_bit = (i < 64) ? src[i] : 1'b0;
                end
                chk("dr_tdo", 64'(tdo), 64'(exp_bit));
                if (i == pause_at && i != n - 1) begin
                    step(1'b0, 1'b0);
                    chk("pause_tdo", 64'(tdo), 64'd0);
                    step(1'b0, 1'b1);
                    step(1'b1, 1'b0);
                    step(1'b0, 1'b0);
                end
            end
        end
        step(1'b1, 1'b0);
        chk("valid_pre", 64'(dr_valid), 64'd0);
        step(1'b0, 1'b0);
        kept = (n > 64) ? 64 : n;
        exp_data = 64'd0;
        for (int i = 0; i < kept; i++) exp_data[i] = bits[i];
        chk("dr_valid", 64'(dr_valid), 64'd1);
        chk("dr_data", dr_data, exp_data);
        chk("dr_len", 64'(dr_len), 64'(kept));
        chk("dr_ir", 64'(dr_ir), 64'(m_ir));
        chk("dr_overflow", 64'(dr_overflow), (n > 64) ? 64'd1 : 64'd0);
        step(1'b0, 1'b0);
        chk("valid_post", 64'(dr_valid), 64'd0);
        chk("dr_data_hold", dr_data, exp_data);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [52:0]  v53;
        logic [127:0] b;
        int           r, n, p;

        nxt0[4'hF] = 4'hC; nxt1[4'hF] = 4'hF;
        nxt0[4'hC] = 4'hC; nxt1[4'hC] = 4'h7;
        nxt0[4'h7] = 4'h6; nxt1[4'h7] = 4'h4;
        nxt0[4'h6] = 4'h2; nxt1[4'h6] = 4'h1;
        nxt0[4'h2] = 4'h2; nxt1[4'h2] = 4'h1;
        nxt0[4'h1] = 4'h3; nxt1[4'h1] = 4'h5;
        nxt0[4'h3] = 4'h3; nxt1[4'h3] = 4'h0;
        nxt0[4'h0] = 4'h2; nxt1[4'h0] = 4'h5;
        nxt0[4'h5] = 4'hC; nxt1[4'h5] = 4'h7;
        nxt0[4'h4] = 4'hE; nxt1[4'h4] = 4'hF;
        nxt0[4'hE] = 4'hA; nxt1[4'hE] = 4'h9;
        nxt0[4'hA] = 4'hA; nxt1[4'hA] = 4'h9;
        nxt0[4'h9] = 4'hB; nxt1[4'h9] = 4'hD;
        nxt0[4'hB] = 4'hB; nxt1[4'hB] = 4'h8;
        nxt0[4'h8] = 4'hA; nxt1[4'h8] = 4'hD;
        nxt0[4'hD] = 4'hC; nxt1[4'hD] = 4'h7;

        rst_n = 1'b0; trstn = 1'b1; tms = 1'b1; tdi = 1'b0; resp_data_i = 64'd0;
        repeat (3) @(posedge jtag_clk_i);
        #1;
        m_state = 4'hF;
        m_ir    = 4'h2;
        chk("rst_state", 64'(tap_state), 64'hF);
        chk("rst_ir", 64'(ir_o), 64'h2);
        chk("rst_tdo", 64'(tdo), 64'd0);
        chk("rst_valid", 64'(dr_valid), 64'd0);
        chk("rst_data", dr_data, 64'd0);
        chk("rst_len", 64'(dr_len), 64'd0);
        chk("rst_dr_ir", 64'(dr_ir), 64'd0);
        chk("rst_ovf", 64'(dr_overflow), 64'd0);
        @(negedge jtag_clk_i);
        rst_n = 1'b1;

        // Into Shift-DR, then five tms=1 edges back to Test-Logic-Reset.
        step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b0);
        chk("tms5_state", 64'(tap_state), 64'hF);
        chk("tms5_ir", 64'(ir_o), 64'h2);
        step(1'b0, 1'b0);

        // Directed scans.
        shift_ir(4'h8);
        shift_dr(6, 128'h20, 64'd0, -1);
        v53 = {5'h3, 32'h1A10_7008, 16'h0001};
        shift_dr(53, 128'(v53), 64'd0, -1);
        shift_dr(64, 128'd0, 64'hDEAD_BEEF_0123_4567, -1);
        shift_dr(0, 128'd0, 64'd0, -1);
        shift_ir(4'h2);
        shift_dr(32, 128'h5A5A_1234, 64'd0, -1);
        shift_ir(4'hF);
        shift_dr(4, 128'hD, 64'd0, -1);
        shift_dr(70, {$urandom(), $urandom(), $urandom(), $urandom()}, 64'd0, 10);

        // Randomized scans.
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 3);
            case (r)
                0:       shift_ir(4'h2);
                1:       shift_ir(4'h8);
                2:       shift_ir(4'hF);
                default: shift_ir(4'($urandom_range(0, 15)));
            endcase
            repeat ($urandom_range(1, 2)) begin
                n = $urandom_range(0, 80);
                p = (n > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(0, n - 2) : -1;
                b = {$urandom(), $urandom(), $urandom(), $urandom()};
                shift_dr(n, b, {$urandom(), $urandom()}, p);
            end
        end

        // TAP reset in the middle of Shift-DR discards the capture.
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b1);
        @(negedge jtag_clk_i);
        trstn = 1'b0;
        #1;
        m_state = 4'hF;
        m_ir    = 4'h2;
        chk("trst_state", 64'(tap_state), 64'hF);
        chk("trst_ir", 64'(ir_o), 64'h2);
        chk("trst_tdo", 64'(tdo), 64'd0);
        chk("trst_len", 64'(dr_len), 64'd0);
        chk("trst_data", dr_data, 64'd0);
        @(negedge jtag_clk_i);
        trstn = 1'b1;
        repeat (6) begin
            step(1'b0, 1'b0);
            chk("trst_no_valid", 64'(dr_valid), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
